// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state encoding (IDLE, REQ, DONE)
//   - helpers: byte-enable generation and funct3 legality check
// Optional feature macro used by the LSU: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word. Low address bits that
  // do not select a lane for the access size are ignored (truncation).
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Stores accept B/H/W; loads additionally accept BU/HU.
  function automatic logic code_ok(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (purely combinational).
//   funct3     : RV32I width/sign code of the captured op
//   addr_lo    : effective address bits [1:0]
//   store_data : rs2 value to be stored
//   mem_rdata  : word returned by data memory
//   be         : byte enables for the accessed lanes
//   wdata      : lane-replicated store data
//   load_data  : selected lane, sign- or zero-extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  always_comb begin
    be       = calc_be(funct3[1:0], addr_lo);
    // funct3[2] marks the unsigned load variants
    sign_en  = ~funct3[2];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (addr_lo)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    case (funct3[1:0])
      2'b00: begin
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7] & sign_en}}, byte_sel};
      end
      2'b01: begin
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_sel[15] & sign_en}}, half_sel};
      end
      default: begin
        wdata     = store_data;
        load_data = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes the ALU result as effective address and rs2 as
// store data, runs one data-memory transaction over a req/ready handshake,
// and returns an aligned, extended load result.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   op_valid/op_we/op_funct3/op_addr/op_wdata : op request (sampled in IDLE)
//   busy, done, rdata   : core-side status and load result
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata  : memory request (stable in REQ)
//   mem_ready, mem_rdata: memory response
//   misalign_err        : only with LSU_MISALIGN_TRAP_EN; pulses with done on
//                         a misaligned half/word op that was not issued.
// Without LSU_MISALIGN_TRAP_EN, misaligned low address bits are truncated.
module lsu
  import lsu_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RDATA_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_we,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign_err
`endif
);

  state_t            state_q, state_d;
  logic              we_p0;
  logic [2:0]        funct3_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;
  logic              trap;
  logic              issue;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_load;
  logic              in_req;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = code_ok(op_we, op_funct3) &&
                (((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  // Illegal codes and trapped ops bypass REQ and complete without memory access
  assign issue = code_ok(op_we, op_funct3) && !trap;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op_valid) state_d = issue ? REQ : DONE;
      REQ:     if (mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture stage: op fields held for the whole transaction
  always_ff @(posedge clk) begin
    if (state_q == IDLE && op_valid) begin
      we_p0     <= op_we;
      funct3_p0 <= op_funct3;
      addr_p0   <= op_addr;
      wdata_p0  <= op_wdata;
    end
  end

  lsu_align u_align (
    .funct3     (funct3_p0),
    .addr_lo    (addr_p0[1:0]),
    .store_data (wdata_p0),
    .mem_rdata  (mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // Request stage: outputs derived from captured fields, zero outside REQ
  assign in_req    = (state_q == REQ);
  assign busy      = in_req;
  assign mem_req   = in_req;
  assign done      = (state_q == DONE);
  assign mem_we    = in_req && we_p0;
  assign mem_addr  = in_req ? {addr_p0[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = in_req ? al_be : 4'b0000;
  assign mem_wdata = (in_req && we_p0) ? al_wdata : 32'h0;

  // Completion stage: rdata only changes when a load finishes
  always_ff @(posedge clk) begin
    if (rst)                           rdata <= RDATA_RST;
    else if (in_req && mem_ready && !we_p0) rdata <= al_load;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)                            misalign_err <= 1'b0;
    else if (state_q == IDLE && op_valid) misalign_err <= trap;
    else if (state_q == DONE)           misalign_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed ops from the test plan followed by randomized ops,
// all checked against a byte-lane reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_we;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  lsu dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_we     (op_we),
    .op_funct3 (op_funct3),
    .op_addr   (op_addr),
    .op_wdata  (op_wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit we, input int f3);
    if (we) return f3 <= 2;
    return (f3 <= 2) || (f3 == 4) || (f3 == 5);
  endfunction

  function automatic int m_size(input int f3);
    return 1 << (f3 % 4);              // bytes: 1, 2 or 4
  endfunction

  function automatic int m_lane(input int f3, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    return off - (off % m_size(f3));   // lowest lane actually accessed
  endfunction

  function automatic logic [3:0] m_be(input int f3, input logic [31:0] a);
    int v;
    v = ((1 << m_size(f3)) - 1) << m_lane(f3, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_store(input int f3, input logic [31:0] d);
    case (m_size(f3))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v;
    int sz;
    sz = m_size(f3);
    if (sz == 4) return word;
    v = (word >> (8 * m_lane(f3, a))) % (32'd1 << (8 * sz));
    if (f3 < 4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  // One op from op_valid through done; mem_ready after 'waits' wait cycles.
  task automatic run_op(input bit we, input int f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word, input int waits);
    bit legal, trap, access;
    legal = m_legal(we, f3);
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = legal && ((a % m_size(f3)) != 0);
`endif
    access = legal && !trap;
    @(negedge clk);
    op_valid = 1'b1; op_we = we; op_funct3 = f3[2:0]; op_addr = a; op_wdata = wd;
    // ready/rdata outside REQ must be ignored
    if (!access) begin mem_ready = 1'b1; mem_rdata = $urandom; end
    @(posedge clk); #1;
    op_valid = 1'b0; op_addr = $urandom; op_wdata = $urandom; mem_ready = 1'b0;
    if (access) begin
      for (int w = 0; w <= waits; w++) begin
        chk("req_mem_req", mem_req, 1);
        chk("req_busy", busy, 1);
        chk("req_done", done, 0);
        chk("req_mem_we", mem_we, we);
        chk("req_mem_addr", mem_addr, a - (a % 4));
        chk("req_mem_be", mem_be, m_be(f3, a));
        chk("req_mem_wdata", mem_wdata, we ? m_store(f3, wd) : 32'h0);
        @(negedge clk);
        if (w == waits) begin mem_ready = 1'b1; mem_rdata = word; end
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
      if (!we) model_rdata = m_load(f3, a, word);
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_mem_req", mem_req, 0);
    chk("done_rdata", rdata, model_rdata);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("done_misalign_err", misalign_err, trap);
`endif
    @(posedge clk); #1;
    chk("after_done", done, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("after_misalign_err", misalign_err, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_funct3 = 3'b0;
    op_addr = 32'h0; op_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    model_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    run_op(1'b0, 2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);   // LW
    run_op(1'b0, 0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);   // LB
    run_op(1'b0, 4, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1);   // LBU
    run_op(1'b1, 1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3);   // SH, 3 waits
    run_op(1'b1, 4, 32'h0000_0300, 32'h5555_AAAA, 32'h0, 0);   // illegal store
    run_op(1'b0, 3, 32'h0000_0304, 32'h0, 32'h1111_1111, 0);   // illegal load
    run_op(1'b0, 2, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0);   // misaligned LW
    run_op(1'b0, 1, 32'h0000_0107, 32'h0, 32'h8001_7FFE, 2);   // misaligned LH

    // Second op while busy is ignored, then reset during REQ
    @(negedge clk);
    op_valid = 1'b1; op_we = 1'b0; op_funct3 = 3'b010; op_addr = 32'h300;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("rq_mem_req", mem_req, 1);
    @(negedge clk);
    op_valid = 1'b1; op_we = 1'b1; op_funct3 = 3'b010; op_addr = 32'h400;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("ign_mem_addr", mem_addr, 32'h300);
    chk("ign_mem_we", mem_we, 0);
    chk("ign_busy", busy, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdata", rdata, 32'h0);
    model_rdata = 32'h0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", done, 0);
    chk("post_rst_mem_req", mem_req, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
             $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
